image_mem_arbiter: RTL and testbench



---
 rtl/image_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_image_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_mem_arbiter.sv
// Shares the single-port image memory between the SDRAM loader (writes) and the
// VGA display (reads), sequencing image loads through an IDLE/LOAD/RUN machine.
module image_mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 24,
  parameter int N_WORDS  = 512,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_din,
  output logic              ld_gnt,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              load_done,
  output logic              ld_err
);
  localparam int CNT_W  = $clog2(N_WORDS + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(N_WORDS);
  localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(N_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  ld_count;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_pend;
  logic              ld_elig;
  logic              disp_elig;
  logic              ld_win;
  logic              disp_win;
  logic              ld_in_range;
  logic              write_done;
  logic              load_finish;

  // A request seen while its own grant is high is the one just served.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    ld_win    = 1'b0;
    disp_win  = 1'b0;
    ld_elig   = ld_req && !ld_gnt && (state == LOAD);
    disp_elig = disp_req && !disp_gnt;
    if (state == LOAD) begin
      if (disp_elig && (!ld_elig || wait_cnt == WAIT_LIMIT)) disp_win = 1'b1;
      else                                                   ld_win   = ld_elig;
    end else begin
      disp_win = disp_elig;
    end
  end

  assign ld_in_range = {1'b0, ld_addr} < ADDR_LIMIT;
  // mem_we is only ever raised for an in-range loader grant, so it marks a counted write.
  assign write_done  = (state == LOAD) && mem_we;
  assign load_finish = write_done && (ld_count == LAST_COUNT) && !start;

  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= IDLE;
      ld_count   <= '0;
      wait_cnt   <= '0;
      rd_pend    <= 1'b0;
      ld_gnt     <= 1'b0;
      disp_gnt   <= 1'b0;
      disp_rdata <= '0;
      disp_valid <= 1'b0;
      mem_a      <= '0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
      load_done  <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      ld_gnt   <= ld_win;
      disp_gnt <= disp_win;
      mem_we   <= ld_win && ld_in_range;
      if (ld_win) begin
        mem_a   <= ld_addr;
        mem_din <= ld_din;
      end else if (disp_win) begin
        mem_a <= disp_addr;
      end
      if (ld_win && !ld_in_range) ld_err <= 1'b1;

      // Memory returns data one cycle after the issue cycle; capture it the cycle after that.
      rd_pend    <= disp_gnt;
      disp_valid <= rd_pend;
      if (rd_pend) disp_rdata <= mem_dout;

      if (state != LOAD || disp_win || load_finish) wait_cnt <= '0;
      else if (disp_elig && wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            ld_count <= '0;
          end
        end
        LOAD: begin
          if (start) begin
            ld_count <= '0;
          end else if (write_done) begin
            ld_count <= ld_count + 1'b1;
            if (load_finish) begin
              state     <= RUN;
              load_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (start) begin
            state     <= LOAD;
            ld_count  <= '0;
            load_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_mem_arbiter.sv
// Scoreboard bench for image_mem_arbiter: stimulus pushes expected writes/reads,
// a negedge monitor pops and compares whenever mem_we or disp_valid appears.
module tb_image_mem_arbiter;
  localparam int ADDR_W   = 10;  // wide enough to present the out-of-range address 600
  localparam int DATA_W   = 24;
  localparam int N_WORDS  = 512;
  localparam int MAX_WAIT = 4;

  logic              clk50 = 1'b0;
  logic              reset, start, ld_req, disp_req;
  logic [ADDR_W-1:0] ld_addr, disp_addr, mem_a;
  logic [DATA_W-1:0] ld_din, disp_rdata, mem_din, mem_dout;
  logic              ld_gnt, disp_gnt, disp_valid, mem_we, load_done, ld_err;

  always #5 clk50 = ~clk50;

  image_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WORDS(N_WORDS), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk50(clk50), .reset(reset), .start(start),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_gnt(ld_gnt),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_valid(disp_valid),
    .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .load_done(load_done), .ld_err(ld_err)
  );

  // Image memory: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
  always @(posedge clk50) begin
    if (mem_we) mem[mem_a] <= mem_din;
    mem_dout <= mem[mem_a];
  end

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { logic [DATA_W-1:0] d; int cyc; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  wr_t w_exp;
  rd_t r_exp;

  int checks = 0, errors = 0, cyc = 0;
  int ld_gnt_cnt = 0, mem_we_cnt = 0, valid_cnt = 0;
  int last_gnt_cyc, gap_errs, early_done;
  int g0, w0, v0;
  bit last_we;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk50) begin
    check("gnt_exclusive", int'(ld_gnt && disp_gnt), 0);
    if (ld_gnt) ld_gnt_cnt++;
    if (mem_we) begin
      mem_we_cnt++;
      check("mem_we_expected", int'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        w_exp = wr_q.pop_front();
        check("mem_a", int'(mem_a), int'(w_exp.a));
        check("mem_din", int'(mem_din), int'(w_exp.d));
      end
    end
    if (disp_valid) begin
      valid_cnt++;
      check("disp_valid_expected", int'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) begin
        r_exp = rd_q.pop_front();
        check("disp_rdata", int'(disp_rdata), int'(r_exp.d));
        check("read_latency_cycle", cyc, r_exp.cyc);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk50); #1;
    start = 1'b0;
  endtask

  // One loader write with data = addr*3; returns just after the edge following its grant.
  task automatic ld_write(input int a);
    int t = 0;
    ld_req  = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_din  = DATA_W'(a * 3);
    if (a < N_WORDS) wr_q.push_back('{a: ADDR_W'(a), d: DATA_W'(a * 3)});
    do begin @(negedge clk50); t++; end while (!ld_gnt && t < 40);
    check("ld_gnt_seen", int'(ld_gnt), 1);
    if (ld_gnt) begin
      last_we = mem_we;
      if (load_done) early_done++;
      if (last_gnt_cyc >= 0 && cyc - last_gnt_cyc != 2) gap_errs++;
      last_gnt_cyc = cyc;
    end
    @(posedge clk50); #1;
  endtask

  task automatic ld_seq(input int first, input int n);
    last_gnt_cyc = -1;
    gap_errs     = 0;
    early_done   = 0;
    for (int i = 0; i < n; i++) ld_write(first + i);
    ld_req = 1'b0;
  endtask

  task automatic disp_read(input int a, input int exp);
    int t = 0;
    disp_req  = 1'b1;
    disp_addr = ADDR_W'(a);
    do begin @(negedge clk50); t++; end while (!disp_gnt && t < 40);
    check("disp_gnt_seen", int'(disp_gnt), 1);
    if (disp_gnt) rd_q.push_back('{d: DATA_W'(exp), cyc: cyc + 2});
    @(posedge clk50); #1;
    disp_req = 1'b0;
  endtask

  // Display asks only on cycles where the loader is also eligible, so it loses
  // each time until the wait counter saturates.
  task automatic starve();
    int denied = 0;
    int granted_at = -1;
    bit req_prev = 1'b0;
    disp_addr = ADDR_W'(300);
    for (int c = 0; c < 30 && granted_at < 0; c++) begin
      @(negedge clk50);
      if (req_prev) begin
        if (disp_gnt) begin
          granted_at = denied;
          rd_q.push_back('{d: DATA_W'(900), cyc: cyc + 2});
        end else if (ld_gnt) begin
          denied++;
        end
      end
      disp_req = !ld_gnt && granted_at < 0;
      req_prev = disp_req;
    end
    disp_req = 1'b0;
    check("starve_denials_before_grant", granted_at, MAX_WAIT);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ld_req = 1'b0; disp_req = 1'b0;
    ld_addr = '0; ld_din = '0; disp_addr = '0;
    repeat (3) @(posedge clk50);
    #1 reset = 1'b0;
    @(negedge clk50);
    check("rst_ld_gnt", int'(ld_gnt), 0);
    check("rst_disp_gnt", int'(disp_gnt), 0);
    check("rst_disp_valid", int'(disp_valid), 0);
    check("rst_disp_rdata", int'(disp_rdata), 0);
    check("rst_mem_a", int'(mem_a), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_din", int'(mem_din), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_ld_err", int'(ld_err), 0);

    // Reset lands while a read is in flight: its data must never appear.
    mem[5] = 24'h00ABCD;
    disp_addr = ADDR_W'(5);
    disp_req  = 1'b1;
    begin
      int t = 0;
      do begin @(negedge clk50); t++; end while (!disp_gnt && t < 10);
    end
    check("midread_gnt_seen", int'(disp_gnt), 1);
    v0 = valid_cnt;
    reset = 1'b1; disp_req = 1'b0;
    @(posedge clk50); #1 reset = 1'b0;
    repeat (5) @(negedge clk50);
    check("midread_no_valid", valid_cnt - v0, 0);
    check("midread_disp_rdata", int'(disp_rdata), 0);

    // IDLE never grants the loader.
    g0 = ld_gnt_cnt;
    ld_req = 1'b1; ld_addr = ADDR_W'(3);
    repeat (6) @(negedge clk50);
    check("idle_no_ld_gnt", ld_gnt_cnt - g0, 0);
    ld_req = 1'b0;
    @(posedge clk50); #1;

    // Full image load.
    pulse_start();
    g0 = ld_gnt_cnt;
    ld_seq(0, N_WORDS);
    check("full_ld_gnt_count", ld_gnt_cnt - g0, N_WORDS);
    check("full_gnt_spacing_errs", gap_errs, 0);
    check("full_done_early", early_done, 0);
    @(negedge clk50);
    check("full_load_done", int'(load_done), 1);
    check("full_wr_q_drained", wr_q.size(), 0);

    // RUN: loader shut out, display reads the loaded image.
    g0 = ld_gnt_cnt; w0 = mem_we_cnt;
    ld_req = 1'b1; ld_addr = ADDR_W'(7); ld_din = 24'h123456;
    disp_read(10'h1FF, 1533);
    disp_read(0, 0);
    disp_read(300, 900);
    repeat (4) @(negedge clk50);
    check("run_no_ld_gnt", ld_gnt_cnt - g0, 0);
    check("run_no_mem_we", mem_we_cnt - w0, 0);
    check("run_reads_done", rd_q.size(), 0);
    ld_req = 1'b0;
    @(posedge clk50); #1;

    pulse_start();
    @(negedge clk50);
    check("start_in_run_drops_done", int'(load_done), 0);

    // Starvation bound, then plain contention with both requesting back to back.
    fork
      ld_seq(0, 6);
      starve();
    join
    repeat (4) @(negedge clk50);
    g0 = ld_gnt_cnt;
    fork
      ld_seq(6, 10);
      for (int i = 0; i < 5; i++) disp_read(300 + i, (300 + i) * 3);
    join
    repeat (4) @(negedge clk50);
    check("contention_ld_gnt_count", ld_gnt_cnt - g0, 10);
    check("contention_reads_done", rd_q.size(), 0);
    @(posedge clk50); #1;

    // Out-of-range write: granted, no write, sticky error, not counted.
    ld_write(600);
    ld_req = 1'b0;
    check("oor_mem_we", int'(last_we), 0);
    @(negedge clk50);
    check("oor_ld_err", int'(ld_err), 1);
    @(posedge clk50); #1;
    ld_seq(16, N_WORDS - 16);
    check("oor_not_counted", early_done, 0);
    @(negedge clk50);
    check("oor_load_done", int'(load_done), 1);
    check("ld_err_sticky_run", int'(ld_err), 1);
    @(posedge clk50); #1;

    // Restart inside LOAD at ld_count = 100.
    pulse_start();
    ld_seq(0, 100);
    pulse_start();
    @(negedge clk50);
    check("restart_still_load", int'(load_done), 0);
    @(posedge clk50); #1;
    ld_seq(0, N_WORDS - 1);
    check("restart_count_cleared", early_done, 0);
    ld_seq(N_WORDS - 1, 1);
    check("restart_last_not_early", early_done, 0);
    @(negedge clk50);
    check("restart_load_done", int'(load_done), 1);
    check("ld_err_survives_start", int'(ld_err), 1);

    // start and reset together: reset wins, back to IDLE.
    start = 1'b1; reset = 1'b1;
    @(posedge clk50); #1;
    start = 1'b0; reset = 1'b0;
    @(negedge clk50);
    check("start_reset_load_done", int'(load_done), 0);
    check("start_reset_ld_err", int'(ld_err), 0);
    g0 = ld_gnt_cnt;
    ld_req = 1'b1; ld_addr = ADDR_W'(5);
    repeat (6) @(negedge clk50);
    check("start_reset_idle_no_ld_gnt", ld_gnt_cnt - g0, 0);
    ld_req = 1'b0;
    @(posedge clk50); #1;
    disp_read(300, 900);

    repeat (6) @(negedge clk50);
    check("final_wr_q_empty", wr_q.size(), 0);
    check("final_rd_q_empty", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
